l1l2_bus_arbiter: RTL and testbench

- Shares the single L1→L2 request port (stb/we/ack handshake, 32-bit address, 64-bit data) between two L1 requesters: port 0 = instruction L1, port 1 = data L1.
- Round-robin arbitration, one outstanding L2 transaction at a time.
- Registered, stable L2-side signals.
- Ack-timeout watchdog that terminates hung transactions with an error response.

---
 rtl/l1l2_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_l1l2_bus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1l2_bus_arbiter.sv
// Round-robin arbiter sharing one L1->L2 request port between I-L1 and D-L1.
// One outstanding transaction, registered L2 side, ack-timeout watchdog.
module l1l2_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_stb,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_stb,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ack,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic              l2_stb_q, l2_stb_d;
  logic              l2_we_q, l2_we_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r0_err_q, r0_err_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic              r1_ack_q, r1_ack_d;
  logic              r1_err_q, r1_err_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  logic req, win, own, tmo;

  assign req = r0_stb | r1_stb;
  // On a tie the port that did not win last time goes next.
  assign win = (r0_stb & r1_stb) ? ~last_q : r1_stb;
  assign own = grant_q[1];
  assign tmo = (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      grant_q    <= '0;
      l2_stb_q   <= 1'b0;
      l2_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      r0_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_ack_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      l2_stb_q   <= l2_stb_d;
      l2_we_q    <= l2_we_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      r0_ack_q   <= r0_ack_d;
      r0_err_q   <= r0_err_d;
      r0_rdata_q <= r0_rdata_d;
      r1_ack_q   <= r1_ack_d;
      r1_err_q   <= r1_err_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = WAIT;
      WAIT: if (l2_ack || tmo) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    l2_stb_d   = l2_stb_q;
    l2_we_d    = l2_we_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    r0_ack_d   = r0_ack_q;
    r0_err_d   = r0_err_q;
    r0_rdata_d = r0_rdata_q;
    r1_ack_d   = r1_ack_q;
    r1_err_d   = r1_err_q;
    r1_rdata_d = r1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          l2_stb_d   = 1'b1;
          l2_we_d    = win ? r1_we : r0_we;
          l2_addr_d  = win ? r1_addr : r0_addr;
          l2_wdata_d = win ? r1_wdata : r0_wdata;
          grant_d    = win ? 2'b10 : 2'b01;
          last_d     = win;
          cnt_d      = '0;
        end
      end
      WAIT: begin
        if (l2_ack || tmo) begin
          l2_stb_d = 1'b0;
          r0_ack_d = ~own;
          r1_ack_d = own;
          r0_err_d = ~own & ~l2_ack;
          r1_err_d = own & ~l2_ack;
          if (l2_ack && !l2_we_q) begin
            if (own) r1_rdata_d = l2_rdata;
            else     r0_rdata_d = l2_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        r0_ack_d = 1'b0;
        r0_err_d = 1'b0;
        r1_ack_d = 1'b0;
        r1_err_d = 1'b0;
        grant_d  = 2'b00;
      end
      default: ;
    endcase
  end

  assign grant    = grant_q;
  assign l2_stb   = l2_stb_q;
  assign l2_we    = l2_we_q;
  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign r0_ack   = r0_ack_q;
  assign r0_err   = r0_err_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_ack   = r1_ack_q;
  assign r1_err   = r1_err_q;
  assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_l1l2_bus_arbiter.sv
// Bench for l1l2_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level requester/L2 model.
module tb_l1l2_bus_arbiter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_stb = 0, r0_we = 0;
  logic [31:0] r0_addr = '0;
  logic [63:0] r0_wdata = '0;
  logic        r0_ack, r0_err;
  logic [63:0] r0_rdata;
  logic        r1_stb = 0, r1_we = 0;
  logic [31:0] r1_addr = '0;
  logic [63:0] r1_wdata = '0;
  logic        r1_ack, r1_err;
  logic [63:0] r1_rdata;
  logic        l2_stb, l2_we;
  logic [31:0] l2_addr;
  logic [63:0] l2_wdata;
  logic [63:0] l2_rdata = '0;
  logic        l2_ack = 1'b0;
  logic [1:0]  grant;

  l1l2_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_stb(r0_stb), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_err(r0_err),
    .r0_rdata(r0_rdata),
    .r1_stb(r1_stb), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_err(r1_err),
    .r1_rdata(r1_rdata),
    .l2_stb(l2_stb), .l2_we(l2_we), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ack(l2_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  bit          pend [2];
  logic        we_m [2];
  logic [31:0] addr_m [2];
  logic [63:0] wd_m [2];
  logic [63:0] rd_m [2];
  int          last;
  int          acks [2];
  int          wlast;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input int p, input bit stb, input bit scr);
    logic [31:0] a;
    logic [63:0] d;
    a = scr ? $urandom : addr_m[p];
    d = scr ? {$urandom, $urandom} : wd_m[p];
    if (p == 0) begin
      r0_stb = stb; r0_we = we_m[0]; r0_addr = a; r0_wdata = d;
    end else begin
      r1_stb = stb; r1_we = we_m[1]; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic set_req(input int p, input logic we,
                         input logic [31:0] a, input logic [63:0] d);
    pend[p] = 1; we_m[p] = we; addr_m[p] = a; wd_m[p] = d;
    drive(p, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend[0] = 0; pend[1] = 0;
    drive(0, 1'b0, 1'b0); drive(1, 1'b0, 1'b0);
    l2_ack = 1'b0;
    last = 1; rd_m[0] = '0; rd_m[1] = '0;
    acks[0] = 0; acks[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({l2_stb, l2_we, grant, r0_ack, r0_err, r1_ack, r1_err}), 64'(0));
    chk("rst_addr", 64'(l2_addr), 64'(0));
    chk("rst_wd", l2_wdata, 64'(0));
    chk("rst_rd", r0_rdata | r1_rdata, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One arbitration + completion; lat = L2 ack on that l2_stb cycle,
  // lat > TO means L2 never answers.
  task automatic run_txn(input int lat, input logic [63:0] l2d,
                         input bit late, input bit drop);
    int w, hi;
    bit err, done;
    if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
    else w = pend[1] ? 1 : 0;
    @(posedge clk); #1;
    chk("grant", 64'(grant), 64'(w ? 2'b10 : 2'b01));
    chk("l2_wd", l2_wdata, wd_m[w]);
    last = w;
    wlast = w;
    hi = 0; done = 0;
    while (!done) begin
      hi++;
      chk("hold", 64'({l2_stb, r0_ack, r1_ack, l2_we, l2_addr}),
          64'({1'b1, 2'b00, we_m[w], addr_m[w]}));
      chk("hold_wd", l2_wdata, wd_m[w]);
      if (drop && hi == 1) drive(w, 1'b0, 1'b1);
      if (hi == lat) begin l2_ack = 1'b1; l2_rdata = l2d; end
      @(posedge clk); #1;
      l2_ack = 1'b0;
      l2_rdata = {$urandom, $urandom};
      if (hi == lat || hi == TO) done = 1;
    end
    err = (lat > TO);
    if (!err && !we_m[w]) rd_m[w] = l2d;
    chk("resp", 64'({r0_ack, r1_ack, r0_err, r1_err, l2_stb, grant}),
        64'({w ? 2'b01 : 2'b10, err ? (w ? 2'b01 : 2'b10) : 2'b00,
             1'b0, w ? 2'b10 : 2'b01}));
    chk("rdata0", r0_rdata, rd_m[0]);
    chk("rdata1", r1_rdata, rd_m[1]);
    acks[0] += int'(r0_ack);
    acks[1] += int'(r1_ack);
    pend[w] = 0;
    drive(w, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("resp_end", 64'({r0_ack, r1_ack, r0_err, r1_err, l2_stb, grant}), 64'(0));
    if (late) begin
      l2_ack = 1'b1;
      @(posedge clk); #1;
      l2_ack = 1'b0;
      @(posedge clk); #1;
      chk("late", 64'({r0_ack, r1_ack, r0_err, r1_err, l2_stb, grant}), 64'(0));
      chk("late_rd", r0_rdata ^ r1_rdata, rd_m[0] ^ rd_m[1]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    do_reset();

    set_req(0, 1'b0, 32'h0000_1000, 64'h0);
    run_txn(3, 64'h0123_4567_89AB_CDEF, 0, 0);
    chk("t1_rd", r0_rdata, 64'h0123_4567_89AB_CDEF);

    set_req(1, 1'b1, 32'hFFFF_FFF8, 64'hDEAD_BEEF_CAFE_F00D);
    run_txn(1, 64'h1111_2222_3333_4444, 0, 0);
    chk("t2_rd", r1_rdata, 64'h0);

    do_reset();
    set_req(0, 1'b0, 32'h100, 64'h1);
    set_req(1, 1'b0, 32'h200, 64'h2);
    for (int k = 0; k < 4; k++) begin
      run_txn(1, {$urandom, $urandom}, 0, 0);
      set_req(wlast, 1'b0, $urandom, {$urandom, $urandom});
    end
    chk("t3_acks0", 64'(acks[0]), 64'(2));
    chk("t3_acks1", 64'(acks[1]), 64'(2));

    do_reset();
    set_req(1, 1'b0, 32'hABCD_0000, 64'h0);
    run_txn(TO + 1, 64'h0, 1, 0);

    set_req(0, 1'b0, 32'h0000_2000, 64'h0);
    run_txn(TO, 64'h5555_AAAA_5555_AAAA, 0, 0);
    chk("t5_rd", r0_rdata, 64'h5555_AAAA_5555_AAAA);

    do_reset();
    set_req(0, 1'b0, 32'h3000, 64'h3);
    set_req(1, 1'b1, 32'h4000, 64'h4);
    @(posedge clk); #1;
    chk("t6_g0", 64'(grant), 64'(2'b01));
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", 64'({l2_stb, grant, r0_ack, r1_ack}), 64'(0));
    last = 1; rd_m[0] = '0; rd_m[1] = '0;
    @(negedge clk);
    chk("t6_noack", 64'({l2_stb, grant, r0_ack, r1_ack}), 64'(0));
    rst_n = 1'b1;
    run_txn(2, 64'h7777_0000_7777_0000, 0, 0);
    run_txn(1, 64'h0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && 1'($urandom))
          set_req(p, 1'($urandom), $urandom, {$urandom, $urandom});
      if (!pend[0] && !pend[1]) begin
        l2_ack = 1'($urandom);
        @(posedge clk); #1;
        l2_ack = 1'b0;
        chk("idle", 64'({l2_stb, grant, r0_ack, r1_ack}), 64'(0));
      end else begin
        int lat, sel, o;
        sel = int'($urandom_range(0, 7));
        lat = (sel == 0) ? TO + 1 : (sel == 1) ? TO : int'($urandom_range(1, 6));
        o = (pend[0] && pend[1]) ? 0 : (pend[1] ? 0 : 1);
        run_txn(lat, {$urandom, $urandom},
                (o == 1) && !pend[1] && 1'($urandom),
                ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
